// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - sequential AES SubBytes engine, LANES S-boxes per cycle
module gf_inv8 (
    output logic [7:0] o_data,
    input  logic [7:0] i_data
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 == x^-1 in GF(2^8); zero maps to zero as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    assign o_data = gf_inv(i_data);
endmodule

module sbox (
    output logic [7:0] o_data,
    input  logic [7:0] i_data
);
    logic [7:0] w_inv;

    gf_inv8 u_gf_inv (.o_data(w_inv), .i_data(i_data));

    assign o_data = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
    output logic [7:0] o_data,
    input  logic [7:0] i_data
);
    logic [7:0] w_aff;

    assign w_aff = {i_data[6:0], i_data[7]} ^ {i_data[4:0], i_data[7:5]}
                 ^ {i_data[1:0], i_data[7:2]} ^ 8'h05;

    gf_inv8 u_gf_inv (.o_data(o_data), .i_data(w_aff));
endmodule

module sub_bytes_seq #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int N = 16 / LANES;
    localparam logic [3:0] LAST = 4'(N - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_fsm;
    state_t             w_fsm_next;
    logic [127:0]       r_work;
    logic [127:0]       r_out;
    logic [3:0]         r_cnt;
    logic               r_inv;
    logic               w_accept;
    logic               w_last;
    logic [8*LANES-1:0] w_subs;
    logic [127:0]       w_next_work;

    assign w_last    = (r_cnt == LAST);
    assign in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_fsm == DONE);
    assign busy      = (r_fsm != IDLE);
    assign out_state = r_out;

    // The working register rotates left by LANES bytes per cycle: the top
    // LANES bytes are substituted and re-enter at the bottom, so after N
    // cycles every byte is substituted and back in its original position.
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [7:0] w_in_byte;
            logic [7:0] w_fwd;
            logic [7:0] w_sub;

            assign w_in_byte = r_work[127-8*l -: 8];

            sbox u_sbox (.o_data(w_fwd), .i_data(w_in_byte));

            if (INV_EN != 0) begin : g_inv
                logic [7:0] w_inv_byte;
                inv_sbox u_inv_sbox (.o_data(w_inv_byte), .i_data(w_in_byte));
                assign w_sub = r_inv ? w_inv_byte : w_fwd;
            end else begin : g_fwd
                assign w_sub = w_fwd;
            end

            assign w_subs[8*LANES-1-8*l -: 8] = w_sub;
        end

        if (LANES == 16) begin : g_full
            assign w_next_work = w_subs;
        end else begin : g_rot
            assign w_next_work = {r_work[127-8*LANES:0], w_subs};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    if (w_accept) w_fsm_next = RUN;
            RUN:     if (w_last) w_fsm_next = DONE;
            DONE: begin
                if (w_accept)       w_fsm_next = RUN;
                else if (out_ready) w_fsm_next = IDLE;
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= 128'h0;
            r_out  <= 128'h0;
            r_cnt  <= 4'd0;
            r_inv  <= 1'b0;
        end else if (w_accept) begin
            r_work <= in_state;
            r_inv  <= (INV_EN != 0) ? in_inv : 1'b0;
            r_cnt  <= 4'd0;
        end else if (r_fsm == RUN) begin
            r_work <= w_next_work;
            r_cnt  <= r_cnt + 4'd1;
            if (w_last) r_out <= w_next_work;
        end
    end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb/tb_sub_bytes_seq.sv - self-checking bench for sub_bytes_seq across LANES/INV_EN configurations
module tb_sub_bytes_seq;
    localparam int ND = 6;

    localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] ALL_63   = {16{8'h63}};
    localparam logic [127:0] B0_IN    = {8'h53, 120'h0};
    localparam logic [127:0] B0_OUT   = {8'hed, {15{8'h63}}};

    function automatic int lanes_of(int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 4;
            3: return 8;
            4: return 16;
            default: return 4;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [ND];
    logic         in_ready  [ND];
    logic [127:0] in_state  [ND];
    logic         in_inv    [ND];
    logic         out_valid [ND];
    logic         out_ready [ND];
    logic [127:0] out_state [ND];
    logic         busy      [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sub_bytes_seq #(.LANES(lanes_of(g)), .INV_EN((g == 5) ? 0 : 1)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_inv    (in_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    // S-box built by walking the multiplicative group with generator 3 and its inverse
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fwd_tab[p] = x ^ 8'h63;
        end
        fwd_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = 128'h0;
        for (int k = 0; k < 16; k++) begin
            b = s[127-8*k -: 8];
            r[127-8*k -: 8] = inv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    task automatic do_txn(input int d, input logic [127:0] st, input logic inv, input logic toggle,
                          output logic [127:0] res, output int lat, output logic busy_ok);
        int w;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_state[d] = st;
        in_inv[d]   = inv;
        w = 0;
        while (!in_ready[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 40) begin
            if (!busy[d]) busy_ok = 1'b0;
            if (out_valid[d]) break;
            if (toggle) in_inv[d] = ~in_inv[d];
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!out_valid[d]) begin
            errors++;
            $display("FAIL timeout d%0d out_valid=%b required 1 within 40 cycles", d, out_valid[d]);
        end
        res = out_state[d];
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b1 || out_state[d] !== 128'h0) begin
                errors++;
                $display("FAIL reset d%0d valid=%b busy=%b ready=%b state=%h required 0 0 1 0",
                         d, out_valid[d], busy[d], in_ready[d], out_state[d]);
            end
        end
    endtask

    task automatic test_fips();
        logic [127:0] res;
        int lat;
        logic bok;
        do_txn(2, FIPS_IN, 1'b0, 1'b0, res, lat, bok);
        checks++;
        if (res !== FIPS_OUT || res !== model(FIPS_IN, 1'b0)) begin
            errors++;
            $display("FAIL fips_fwd got %h required %h", res, FIPS_OUT);
        end
        checks++;
        if (lat !== 4 || bok !== 1'b1) begin
            errors++;
            $display("FAIL fips_fwd_latency got lat=%0d busy_ok=%b required 4 1", lat, bok);
        end
        do_txn(2, FIPS_OUT, 1'b1, 1'b0, res, lat, bok);
        checks++;
        if (res !== FIPS_IN) begin
            errors++;
            $display("FAIL fips_inv got %h required %h", res, FIPS_IN);
        end
        do_txn(2, ALL_63, 1'b1, 1'b0, res, lat, bok);
        checks++;
        if (res !== 128'h0) begin
            errors++;
            $display("FAIL inv_all63 got %h required 0", res);
        end
    endtask

    task automatic test_latency_sweep();
        logic [127:0] res;
        int lat;
        logic bok;
        int sweep [4] = '{0, 1, 3, 4};
        for (int i = 0; i < 4; i++) begin
            int d;
            d = sweep[i];
            do_txn(d, 128'h0, 1'b0, 1'b0, res, lat, bok);
            checks++;
            if (res !== ALL_63 || lat !== 16 / lanes_of(d) || bok !== 1'b1) begin
                errors++;
                $display("FAIL sweep_zero d%0d got %h lat=%0d busy_ok=%b required %h lat=%0d 1",
                         d, res, lat, bok, ALL_63, 16 / lanes_of(d));
            end
            do_txn(d, B0_IN, 1'b0, 1'b0, res, lat, bok);
            checks++;
            if (res !== B0_OUT) begin
                errors++;
                $display("FAIL sweep_order d%0d got %h required %h", d, res, B0_OUT);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] res, st, exp;
        int lat;
        logic bok, inv;
        for (int d = 0; d < ND; d++) begin
            for (int t = 0; t < 4; t++) begin
                st  = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                exp = model(st, (d == 5) ? 1'b0 : inv);
                do_txn(d, st, inv, 1'b0, res, lat, bok);
                checks++;
                if (res !== exp || lat !== 16 / lanes_of(d)) begin
                    errors++;
                    $display("FAIL random d%0d inv=%b got %h lat=%0d required %h lat=%0d",
                             d, inv, res, lat, exp, 16 / lanes_of(d));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b, snap;
        int lat;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid[2] = 1'b1;
        in_state[2] = a;
        in_inv[2]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid[2] = 1'b0;
        lat = 0;
        while (!out_valid[2] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        snap = out_state[2];
        checks++;
        if (out_valid[2] !== 1'b1 || snap !== model(a, 1'b0)) begin
            errors++;
            $display("FAIL bp_first got valid=%b %h required 1 %h", out_valid[2], snap, model(a, 1'b0));
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[2] !== 1'b1 || out_state[2] !== snap || in_ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c%0d valid=%b ready=%b state=%h required 1 0 %h",
                         c, out_valid[2], in_ready[2], out_state[2], snap);
            end
        end
        @(negedge clk);
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        in_state[2]  = b;
        in_inv[2]    = 1'b1;
        #1;
        checks++;
        if (in_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b required 1", in_ready[2]);
        end
        @(posedge clk);
        #1;
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b0;
        checks++;
        if (out_valid[2] !== 1'b0 || busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept valid=%b busy=%b required 0 1", out_valid[2], busy[2]);
        end
        lat = 0;
        while (!out_valid[2] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || out_state[2] !== model(b, 1'b1)) begin
            errors++;
            $display("FAIL b2b_result lat=%0d got %h required lat=4 %h", lat, out_state[2], model(b, 1'b1));
        end
        @(negedge clk);
        out_ready[2] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[2] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] res;
        int lat;
        logic bok;
        @(negedge clk);
        in_valid[2] = 1'b1;
        in_state[2] = FIPS_IN;
        in_inv[2]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid[2] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[2] !== 1'b0 || out_state[2] !== 128'h0 || busy[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid valid=%b state=%h busy=%b ready=%b required 0 0 0 1",
                     out_valid[2], out_state[2], busy[2], in_ready[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
                errors++;
                $display("FAIL reset_discard c%0d valid=%b busy=%b required 0 0", c, out_valid[2], busy[2]);
            end
        end
        do_txn(2, FIPS_OUT, 1'b1, 1'b0, res, lat, bok);
        checks++;
        if (res !== FIPS_IN || lat !== 4) begin
            errors++;
            $display("FAIL reset_recover got %h lat=%0d required %h lat=4", res, lat, FIPS_IN);
        end
    endtask

    task automatic test_mode_latch();
        logic [127:0] res, st;
        int lat;
        logic bok;
        st = {$urandom, $urandom, $urandom, $urandom};
        do_txn(2, st, 1'b0, 1'b1, res, lat, bok);
        checks++;
        if (res !== model(st, 1'b0)) begin
            errors++;
            $display("FAIL latch_fwd got %h required %h", res, model(st, 1'b0));
        end
        do_txn(2, st, 1'b1, 1'b1, res, lat, bok);
        checks++;
        if (res !== model(st, 1'b1)) begin
            errors++;
            $display("FAIL latch_inv got %h required %h", res, model(st, 1'b1));
        end
        do_txn(5, 128'h0, 1'b1, 1'b0, res, lat, bok);
        checks++;
        if (res !== ALL_63 || lat !== 4) begin
            errors++;
            $display("FAIL inv_disabled got %h lat=%0d required %h lat=4", res, lat, ALL_63);
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = 128'h0;
            in_inv[d]    = 1'b0;
            out_ready[d] = 1'b0;
        end
        build_tables();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fips();
        test_latency_sweep();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_mode_latch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
